// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
//   Shared types and constants for the countdown/underflow timer.
//
//   countdown_state_t        : FSM encoding (IDLE, RUN, EXPIRED)
//   COUNTDOWN_DEFAULT_WIDTH  : default counter width in bits
// ---------------------------------------------------------------------------
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        RUN     = 2'b01,
        EXPIRED = 2'b10
    } countdown_state_t;

    localparam int COUNTDOWN_DEFAULT_WIDTH = 4;

endpackage : countdown_pkg

// File: rtl/countdown_underflow_timer.sv
// ---------------------------------------------------------------------------
// countdown_underflow_timer
//   Loadable down-counter with a sticky underflow flag and a single-cycle
//   terminal-count strobe. A load starts a countdown. Each enabled cycle in
//   RUN decrements the count. An enabled cycle at a count of zero is an
//   underflow event.
//
//   Build option: define COUNTDOWN_AUTO_RELOAD_EN to make an underflow
//   reload the counter from the last loaded value and keep running. This
//   gives a periodic timer. Without it, an underflow parks the counter at 0
//   in EXPIRED.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   load           in   load load_value and enter RUN (any state)
//   load_value     in   start / reload value          [WIDTH-1:0]
//   enable         in   decrement qualifier (RUN only)
//   clear_uf       in   clear sticky underflow_out (an underflow event wins)
//   counter_out    out  current count                 [WIDTH-1:0]
//   underflow_out  out  sticky underflow flag
//   tc_pulse       out  one-cycle terminal-count strobe
//   busy           out  high while in RUN
// ---------------------------------------------------------------------------
module countdown_underflow_timer
    import countdown_pkg::*;
#(
    parameter int WIDTH = COUNTDOWN_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             clear_uf,
    output logic [WIDTH-1:0] counter_out,
    output logic             underflow_out,
    output logic             tc_pulse,
    output logic             busy
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    countdown_state_t state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             uf_q, uf_d;
    logic             tc_q, tc_d;
    logic             busy_q, busy_d;
    logic             uf_event;

    // -----------------------------------------------------------------------
    // Next-state logic. Priority: load, then enable. Reset is applied in the
    // register process.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; otherwise a latch would be inferred.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        uf_event = 1'b0;

        if (load) begin
            count_d  = load_value;
            reload_d = load_value;
            state_d  = RUN;
        end else if (state_q == RUN && enable) begin
            if (count_q != '0) begin
                count_d = count_q - ONE;
            end else begin
                uf_event = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                count_d  = reload_q;
`else
                state_d  = EXPIRED;
`endif
            end
        end

        // Set has priority over clear when both happen in the same cycle.
        uf_d   = uf_event | (uf_q & ~clear_uf);
        tc_d   = uf_event;
        busy_d = (state_d == RUN);
    end

`ifndef COUNTDOWN_AUTO_RELOAD_EN
    // Without auto-reload the reload value is recorded on load but never
    // read back. It is folded in here so the register is visibly consumed.
    logic unused_reload;
    assign unused_reload = ^reload_q;
`endif

    // -----------------------------------------------------------------------
    // State register. The reset is synchronous, as in the rest of the
    // timer/counter group.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every flop sample the
        // pre-edge values, regardless of statement order.
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            uf_q     <= 1'b0;
            tc_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            uf_q     <= uf_d;
            tc_q     <= tc_d;
            busy_q   <= busy_d;
        end
    end

    assign counter_out   = count_q;
    assign underflow_out = uf_q;
    assign tc_pulse      = tc_q;
    assign busy          = busy_q;

endmodule : countdown_underflow_timer

// File: tb/tb_countdown_underflow_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_underflow_timer
//   Self-checking bench for countdown_underflow_timer (WIDTH=4). A table of
//   per-cycle {inputs, expected outputs} records is applied in a loop. A few
//   hand-written sequences follow. Expected values depend on whether
//   COUNTDOWN_AUTO_RELOAD_EN is defined for the build.
// ---------------------------------------------------------------------------
module tb_countdown_underflow_timer;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       load;
    logic [3:0] load_value;
    logic       enable;
    logic       clear_uf;
    logic [3:0] counter_out;
    logic       underflow_out;
    logic       tc_pulse;
    logic       busy;

    int errors = 0;
    int checks = 0;

    countdown_underflow_timer #(.WIDTH(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .load_value    (load_value),
        .enable        (enable),
        .clear_uf      (clear_uf),
        .counter_out   (counter_out),
        .underflow_out (underflow_out),
        .tc_pulse      (tc_pulse),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       clr;
        logic [3:0] cnt;
        logic       uf;
        logic       tc;
        logic       bsy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic rst, input logic ld,
                       input logic [3:0] lv, input logic en, input logic clr,
                       input logic [3:0] cnt, input logic uf, input logic tc,
                       input logic bsy);
        vec_t v;
        v.name = name; v.rst = rst; v.ld = ld; v.lv = lv; v.en = en; v.clr = clr;
        v.cnt = cnt; v.uf = uf; v.tc = tc; v.bsy = bsy;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 time unit later.
    task automatic step(input logic rst, input logic ld, input logic [3:0] lv,
                        input logic en, input logic clr);
        reset = rst; load = ld; load_value = lv; enable = en; clear_uf = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic [3:0] cnt,
                             input logic uf, input logic tc, input logic bsy);
        check({name, " cnt"},  32'(counter_out),   32'(cnt));
        check({name, " uf"},   32'(underflow_out), 32'(uf));
        check({name, " tc"},   32'(tc_pulse),      32'(tc));
        check({name, " busy"}, 32'(busy),          32'(bsy));
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_value = '0; enable = 1'b0; clear_uf = 1'b0;

        //   name        rst ld lv  en clr   cnt            uf tc busy
        add("reset",      1, 0, 0,  0, 0,    0,             0, 0, 0);
        for (int i = 0; i < 5; i++)
            add("idle_en", 0, 0, 0, 1, 0,    0,             0, 0, 0);
        add("ld3_en",     0, 1, 3,  1, 0,    3,             0, 0, 1);
        add("dec2",       0, 0, 0,  1, 0,    2,             0, 0, 1);
        add("dec1",       0, 0, 0,  1, 0,    1,             0, 0, 1);
        add("dec0",       0, 0, 0,  1, 0,    0,             0, 0, 1);
        add("uf3",        0, 0, 0,  1, 0,    AR ? 4'd3 : 4'd0, 1, 1, AR);
        add("post_uf1",   0, 0, 0,  1, 0,    AR ? 4'd2 : 4'd0, 1, 0, AR);
        add("post_uf2",   0, 0, 0,  1, 0,    AR ? 4'd1 : 4'd0, 1, 0, AR);
        add("clr_alone",  0, 0, 0,  0, 1,    AR ? 4'd1 : 4'd0, 0, 0, AR);
        add("ld5",        0, 1, 5,  0, 0,    5,             0, 0, 1);
        add("tog_en1",    0, 0, 0,  1, 0,    4,             0, 0, 1);
        add("tog_en0",    0, 0, 0,  0, 0,    4,             0, 0, 1);
        add("tog_en1",    0, 0, 0,  1, 0,    3,             0, 0, 1);
        add("tog_en0",    0, 0, 0,  0, 0,    3,             0, 0, 1);
        add("tog_en1",    0, 0, 0,  1, 0,    2,             0, 0, 1);
        add("ld0",        0, 1, 0,  0, 0,    0,             0, 0, 1);
        add("ld0_en",     0, 1, 0,  1, 0,    0,             0, 0, 1);
        add("uf_clr",     0, 0, 0,  1, 1,    0,             1, 1, AR);
        add("ld9",        0, 1, 9,  0, 0,    9,             1, 0, 1);
        add("dec8",       0, 0, 0,  1, 0,    8,             1, 0, 1);
        add("dec7",       0, 0, 0,  1, 0,    7,             1, 0, 1);
        add("dec6",       0, 0, 0,  1, 0,    6,             1, 0, 1);
        add("rst_mid",    1, 0, 0,  1, 0,    0,             0, 0, 0);
        add("ld1",        0, 1, 1,  0, 0,    1,             0, 0, 1);
        add("ld1_dec0",   0, 0, 0,  1, 0,    0,             0, 0, 1);
        add("ld1_uf",     0, 0, 0,  1, 0,    AR ? 4'd1 : 4'd0, 1, 1, AR);
        add("clr_again",  0, 0, 0,  0, 1,    AR ? 4'd1 : 4'd0, 0, 0, AR);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].ld, vecs[i].lv, vecs[i].en, vecs[i].clr);
            check_all($sformatf("%s[%0d]", vecs[i].name, i),
                      vecs[i].cnt, vecs[i].uf, vecs[i].tc, vecs[i].bsy);
        end

        // Load 2, then hold enable: nine observed cycles including the load.
        step(1, 0, 0, 0, 0);
        step(0, 1, 2, 1, 0);
        for (int k = 0; k < 9; k++) begin
            logic [3:0] e_cnt;
            logic       e_tc, e_bsy, e_uf;
            if (k > 0) step(0, 0, 0, 1, 0);
            if (AR) begin
                e_cnt = 4'(2 - (k % 3));
                e_tc  = (k > 0) && (k % 3 == 0);
                e_bsy = 1'b1;
            end else begin
                e_cnt = (k < 3) ? 4'(2 - k) : 4'd0;
                e_tc  = (k == 3);
                e_bsy = (k < 3);
            end
            e_uf = (k >= 3);
            check_all($sformatf("period2[%0d]", k), e_cnt, e_uf, e_tc, e_bsy);
        end

        // A reset drops the reload value: the block then idles at 0 and
        // ignores enable until the next load.
        step(0, 1, 7, 0, 0);
        step(1, 0, 0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1, 0);
            check_all($sformatf("post_rst_idle[%0d]", k), 4'd0, 1'b0, 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_countdown_underflow_timer
